// File: rtl/vj_scan_pkg.sv
// Shared types and default constants for the Viola-Jones scanning-window sequencer.
package vj_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEVEL,
    WAIT,
    SCAN,
    DONE
  } scan_state_t;

  localparam int WIN_DEFAULT      = 25;
  localparam int INT_WAIT_DEFAULT = 3;

endpackage

// File: rtl/scan_win_scheduler_if.sv
// Loader request/ack and window-coordinate handshake between the scheduler and the vj pipeline.
interface scan_win_scheduler_if #(
  parameter int LEVEL_W = 4,
  parameter int COORD_W = 16
);
  logic               level_req;
  logic [LEVEL_W-1:0] level_idx;
  logic               level_ack;
  logic               win_valid;
  logic               win_ready;
  logic [COORD_W-1:0] win_row;
  logic [COORD_W-1:0] win_col;
  logic               win_last_level;
  logic               win_last;

  modport master (
    output level_req, level_idx, win_valid, win_row, win_col, win_last_level, win_last,
    input  level_ack, win_ready
  );

  modport slave (
    input  level_req, level_idx, win_valid, win_row, win_col, win_last_level, win_last,
    output level_ack, win_ready
  );
endinterface

// File: rtl/scan_win_scheduler_clamp_stepper.sv
// Single-axis window position counter: steps by stride, clamps to the limit, wraps to 0 past it.
module clamp_stepper #(
  parameter int COORD_W  = 16,
  parameter int STRIDE_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                step,
  input  logic [STRIDE_W-1:0] stride,
  input  logic [COORD_W-1:0]  limit,
  output logic [COORD_W-1:0]  pos,
  output logic                wrap
);

  // One extra bit so pos + stride can never wrap before the clamp.
  logic [COORD_W:0] sum;

  assign sum  = {1'b0, pos} + {{(COORD_W + 1 - STRIDE_W){1'b0}}, stride};
  assign wrap = (pos >= limit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= '0;
    end else if (clear) begin
      pos <= '0;
    end else if (step) begin
      if (wrap)                     pos <= '0;
      else if (sum >= {1'b0, limit}) pos <= limit;
      else                          pos <= sum[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/scan_win_scheduler.sv
// Scanning-window sequencer: walks pyramid levels, waits out integral-image latency and
// issues clamped, strided window coordinates to the vj pipeline.
module scan_win_scheduler
  import vj_scan_pkg::*;
#(
  parameter int LEVELS   = 10,
  parameter int LEVEL_W  = 4,
  parameter int COORD_W  = 16,
  parameter int STRIDE_W = 4,
  parameter int WIN      = WIN_DEFAULT,
  parameter int INT_WAIT = INT_WAIT_DEFAULT,
  // The all-zero default fails the dimension check, so every instance must supply real sizes.
  parameter logic [LEVELS-1:0][COORD_W-1:0] LEVEL_WIDTHS  = '0,
  parameter logic [LEVELS-1:0][COORD_W-1:0] LEVEL_HEIGHTS = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [STRIDE_W-1:0] cfg_stride,
  input  logic [LEVEL_W-1:0]  cfg_first_level,
  input  logic [LEVEL_W-1:0]  cfg_last_level,
  scan_win_scheduler_if.master scan,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic [31:0]         win_count
);

  localparam int WAIT_W = (INT_WAIT > 1) ? $clog2(INT_WAIT + 1) : 1;

  for (genvar g = 0; g < LEVELS; g++) begin : g_dim_check
    if (LEVEL_WIDTHS[g] < COORD_W'(WIN) || LEVEL_HEIGHTS[g] < COORD_W'(WIN)) begin : g_bad
      $error("scan_win_scheduler: level %0d is smaller than the window", g);
    end
  end

  scan_state_t         state, state_next;
  logic [STRIDE_W-1:0] stride_q;
  logic [LEVEL_W-1:0]  last_q;
  logic [LEVEL_W-1:0]  level_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [COORD_W-1:0]  max_col, max_row, col, row;
  logic                col_wrap, row_wrap, level_end;
  logic                level_req, win_valid, cfg_ok, start_ok, hs;

  assign cfg_ok    = (cfg_first_level <= cfg_last_level) && (32'(cfg_last_level) < LEVELS);
  assign start_ok  = (state == IDLE) && start && !abort && cfg_ok;
  assign hs        = win_valid && scan.win_ready;
  assign level_end = col_wrap && row_wrap;

  always_comb begin
    max_col = '0;
    max_row = '0;
    for (int i = 0; i < LEVELS; i++) begin
      if (32'(level_q) == i) begin
        max_col = LEVEL_WIDTHS[i]  - COORD_W'(WIN);
        max_row = LEVEL_HEIGHTS[i] - COORD_W'(WIN);
      end
    end
  end

  always_comb begin
    state_next = state;
    level_req  = 1'b0;
    win_valid  = 1'b0;
    done       = 1'b0;
    cfg_err    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) state_next = LEVEL;
          else        cfg_err    = 1'b1;
        end
      end
      LEVEL: begin
        level_req = 1'b1;
        if (scan.level_ack) state_next = (INT_WAIT == 0) ? SCAN : WAIT;
      end
      WAIT: begin
        if (wait_q == WAIT_W'(1)) state_next = SCAN;
      end
      SCAN: begin
        win_valid = 1'b1;
        if (scan.win_ready && level_end) state_next = (level_q == last_q) ? DONE : LEVEL;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including this cycle's outputs.
    if (abort) begin
      state_next = IDLE;
      level_req  = 1'b0;
      win_valid  = 1'b0;
      done       = 1'b0;
      cfg_err    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      stride_q  <= '0;
      last_q    <= '0;
      level_q   <= '0;
      wait_q    <= '0;
      win_count <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        stride_q  <= (cfg_stride == '0) ? STRIDE_W'(1) : cfg_stride;
        last_q    <= cfg_last_level;
        level_q   <= cfg_first_level;
        win_count <= '0;
      end
      if (state == LEVEL && scan.level_ack) wait_q <= WAIT_W'(INT_WAIT);
      else if (state == WAIT)               wait_q <= wait_q - 1'b1;
      if (hs) begin
        win_count <= win_count + 32'd1;
        if (level_end && level_q != last_q) level_q <= level_q + 1'b1;
      end
    end
  end

  // Column advances on every handshake; the row only when the column wraps.
  clamp_stepper #(.COORD_W(COORD_W), .STRIDE_W(STRIDE_W)) u_col (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok || abort),
    .step   (hs),
    .stride (stride_q),
    .limit  (max_col),
    .pos    (col),
    .wrap   (col_wrap)
  );

  clamp_stepper #(.COORD_W(COORD_W), .STRIDE_W(STRIDE_W)) u_row (
    .clock  (clock),
    .reset  (reset),
    .clear  (start_ok || abort),
    .step   (hs && col_wrap),
    .stride (stride_q),
    .limit  (max_row),
    .pos    (row),
    .wrap   (row_wrap)
  );

  assign busy                = (state != IDLE) && !abort;
  assign scan.level_req      = level_req;
  assign scan.level_idx      = level_q;
  assign scan.win_valid      = win_valid;
  assign scan.win_row        = row;
  assign scan.win_col        = col;
  assign scan.win_last_level = win_valid && level_end;
  assign scan.win_last       = win_valid && level_end && (level_q == last_q);

endmodule

// File: tb/tb_scan_win_scheduler.sv
// Randomised bench for scan_win_scheduler against a list-based window reference model.
module tb_scan_win_scheduler;
  localparam int LEVELS = 3, LEVEL_W = 4, COORD_W = 16, STRIDE_W = 4, WIN = 4, INT_WAIT = 3;
  localparam logic [LEVELS-1:0][COORD_W-1:0] WIDTHS  = {16'd4, 16'd6, 16'd8};
  localparam logic [LEVELS-1:0][COORD_W-1:0] HEIGHTS = {16'd4, 16'd5, 16'd6};

  int dim_w [LEVELS] = '{8, 6, 4};
  int dim_h [LEVELS] = '{6, 5, 4};

  typedef struct {
    int row;
    int col;
    bit ll;
    bit last;
  } win_t;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [STRIDE_W-1:0] cfg_stride = '0;
  logic [LEVEL_W-1:0]  cfg_first_level = '0;
  logic [LEVEL_W-1:0]  cfg_last_level = '0;
  logic                busy, done, cfg_err;
  logic [31:0]         win_count;

  scan_win_scheduler_if #(.LEVEL_W(LEVEL_W), .COORD_W(COORD_W)) scan ();

  scan_win_scheduler #(
    .LEVELS(LEVELS), .LEVEL_W(LEVEL_W), .COORD_W(COORD_W), .STRIDE_W(STRIDE_W),
    .WIN(WIN), .INT_WAIT(INT_WAIT), .LEVEL_WIDTHS(WIDTHS), .LEVEL_HEIGHTS(HEIGHTS)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .abort           (abort),
    .cfg_stride      (cfg_stride),
    .cfg_first_level (cfg_first_level),
    .cfg_last_level  (cfg_last_level),
    .scan            (scan.master),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err),
    .win_count       (win_count)
  );

  always #5 clock = ~clock;

  int   n_chk = 0, n_err = 0;
  int   cyc = 0, ack_cyc = 0, hs_cnt = 0, done_cnt = 0, n_exp = 0;
  bit   mon_en = 1'b0, rdy_rand = 1'b0;
  int   ack_delay = 0;
  win_t exp_q[$];
  win_t e;
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [COORD_W-1:0] prev_row = '0, prev_col = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: each axis visits 0, s, 2s, ... clamped to its limit; rows outer, cols inner.
  task automatic build_job(input int first, input int last, input int stride);
    int s;
    int v;
    int rows[$];
    int cols[$];
    win_t w;
    s = (stride == 0) ? 1 : stride;
    exp_q.delete();
    for (int lv = first; lv <= last; lv++) begin
      int mr, mc;
      mr = dim_h[lv] - WIN;
      mc = dim_w[lv] - WIN;
      rows.delete(); cols.delete();
      v = 0; rows.push_back(0);
      while (v < mr) begin v = (v + s > mr) ? mr : v + s; rows.push_back(v); end
      v = 0; cols.push_back(0);
      while (v < mc) begin v = (v + s > mc) ? mc : v + s; cols.push_back(v); end
      foreach (rows[r]) foreach (cols[c]) begin
        w.row  = rows[r];
        w.col  = cols[c];
        w.ll   = (rows[r] == mr) && (cols[c] == mc);
        w.last = w.ll && (lv == last);
        exp_q.push_back(w);
      end
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    int cnt;
    cnt = 0;
    scan.level_ack = 1'b0;
    scan.win_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      scan.win_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scan.level_req && !scan.level_ack) begin
        cnt++;
        if (cnt > ack_delay) begin scan.level_ack = 1'b1; cnt = 0; end
      end else begin
        scan.level_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  always @(negedge clock) begin
    if (mon_en) begin
      if (scan.level_req && scan.level_ack) ack_cyc = cyc;
      if (scan.win_valid && !prev_valid) chk("first_win_latency", 32'(cyc - ack_cyc), INT_WAIT + 1);
      if (prev_valid && !prev_ready && scan.win_valid) begin
        chk("hold_row", 32'(scan.win_row), 32'(prev_row));
        chk("hold_col", 32'(scan.win_col), 32'(prev_col));
      end
      if (scan.win_valid && scan.win_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("extra_window", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("win_row", 32'(scan.win_row), e.row);
          chk("win_col", 32'(scan.win_col), e.col);
          chk("win_last_level", 32'(scan.win_last_level), 32'(e.ll));
          chk("win_last", 32'(scan.win_last), 32'(e.last));
        end
      end
      if (done) done_cnt++;
    end
    prev_valid = scan.win_valid;
    prev_ready = scan.win_ready;
    prev_row   = scan.win_row;
    prev_col   = scan.win_col;
  end

  task automatic pulse_start(input int first, input int last, input int stride);
    @(posedge clock); #1;
    start = 1'b1;
    cfg_first_level = LEVEL_W'(first);
    cfg_last_level  = LEVEL_W'(last);
    cfg_stride      = STRIDE_W'(stride);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_job(input int first, input int last, input int stride,
                         input bit rnd, input int ackd, input bit poke);
    int guard;
    build_job(first, last, stride);
    n_exp = exp_q.size();
    rdy_rand = rnd; ack_delay = ackd; hs_cnt = 0; done_cnt = 0; mon_en = 1'b1;
    pulse_start(first, last, stride);
    @(negedge clock);
    chk("req_after_start", 32'(scan.level_req), 1);
    chk("busy_after_start", 32'(busy), 1);
    if (poke) pulse_start(0, 0, 1);
    guard = 0;
    while (!done && guard < 3000) begin @(negedge clock); guard++; end
    if (guard >= 3000) chk("done_timeout", 0, 1);
    @(negedge clock);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    chk("win_count", win_count, n_exp);
    chk("handshakes", hs_cnt, n_exp);
    chk("windows_left", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    mon_en = 1'b0;
  endtask

  task automatic abort_job(input bit mid_scan);
    int guard;
    build_job(0, 2, 1);
    rdy_rand = 1'b0; ack_delay = 0; hs_cnt = 0; done_cnt = 0; mon_en = 1'b1;
    pulse_start(0, 2, 1);
    guard = 0;
    do begin
      @(negedge clock); guard++;
    end while (guard < 500 && !(mid_scan ? (hs_cnt >= 3 && scan.win_valid)
                                         : (scan.level_req && scan.level_ack && scan.level_idx == 1)));
    if (guard >= 500) chk("abort_arm_timeout", 0, 1);
    @(posedge clock); #1; abort = 1'b1;
    @(negedge clock);
    chk("abort_valid_now", 32'(scan.win_valid), 0);
    chk("abort_busy_now", 32'(busy), 0);
    @(posedge clock); #1; abort = 1'b0;
    @(negedge clock);
    chk("abort_valid", 32'(scan.win_valid), 0);
    chk("abort_req", 32'(scan.level_req), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (10) @(negedge clock);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", 32'(busy), 0);
    chk("abort_count_hold", win_count, hs_cnt);
    if (!mid_scan) chk("abort_wait_count", hs_cnt, 15);
    mon_en = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clock);
    chk("rst_level_req", 32'(scan.level_req), 0);
    chk("rst_win_valid", 32'(scan.win_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_win_count", win_count, 0);
    chk("rst_row_col", 32'({scan.win_row, scan.win_col}), 0);
    @(posedge clock); #1; reset = 1'b0;

    run_job(0, 2, 1, 1'b0, 0, 1'b0);
    run_job(0, 0, 3, 1'b0, 0, 1'b0);
    run_job(0, 2, 1, 1'b1, 5, 1'b1);
    run_job(1, 1, 0, 1'b0, 0, 1'b0);

    pulse_start(2, 1, 1);
    @(negedge clock);
    chk("cfg_err_clear", 32'(cfg_err), 0);
    chk("cfg_err_busy", 32'(busy), 0);
    @(posedge clock); #1; start = 1'b1; cfg_first_level = 4'd1; cfg_last_level = 4'd3;
    @(negedge clock);
    chk("cfg_err_range", 32'(cfg_err), 1);
    @(posedge clock); #1; start = 1'b0;
    @(negedge clock);
    chk("cfg_err_req", 32'(scan.level_req), 0);
    @(posedge clock); #1; start = 1'b1; cfg_first_level = 4'd2; cfg_last_level = 4'd1;
    @(negedge clock);
    chk("cfg_err_order", 32'(cfg_err), 1);
    @(posedge clock); #1; start = 1'b0;
    run_job(0, 2, 2, 1'b0, 1, 1'b0);

    abort_job(1'b0);
    abort_job(1'b1);

    build_job(0, 2, 1);
    rdy_rand = 1'b0; ack_delay = 0; hs_cnt = 0; mon_en = 1'b1;
    pulse_start(0, 2, 1);
    guard = 0;
    while (hs_cnt < 5 && guard < 500) begin @(negedge clock); guard++; end
    if (guard >= 500) chk("reset_arm_timeout", 0, 1);
    mon_en = 1'b0;
    @(posedge clock); #1; reset = 1'b1; #1;
    chk("arst_valid", 32'(scan.win_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", win_count, 0);
    chk("arst_row_col", 32'({scan.win_row, scan.win_col}), 0);
    chk("arst_level_idx", 32'(scan.level_idx), 0);
    @(negedge clock); #1; reset = 1'b0;
    exp_q.delete();
    run_job(1, 2, 2, 1'b0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      int f, l;
      f = $urandom_range(0, LEVELS - 1);
      l = $urandom_range(f, LEVELS - 1);
      run_job(f, l, $urandom_range(0, 7), 1'b1, $urandom_range(0, 4), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/scan_win_scheduler.md
# scan_win_scheduler

Parametrised scanning-window sequencer for the Viola-Jones detection path, replacing the fixed stride-1 walk embedded in the face detector. Walks a configurable range of pyramid levels with a runtime stride and edge clamping. Requests each level's image from the loader, waits out the integral-image latency, then issues window coordinates to the vj pipeline over a valid/ready handshake. Holds no image data: it is coordinates, level control and status only.

## Interface
- LEVELS, 10: number of pyramid levels
- LEVEL_W, 4: width of level index
- COORD_W, 16: width of row/col coordinates
- STRIDE_W, 4: width of cfg_stride
- WIN, 25: window extent in pixels, including the integral-image border
- INT_WAIT, 3: cycles between level_ack and the first window of a level
- LEVEL_WIDTHS, LEVEL_HEIGHTS, no default: packed [LEVELS-1:0][COORD_W-1:0] per-level dimensions; elaboration error if any entry < WIN
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  job start pulse; honoured only in IDLE
- abort  in  1  cancel job from any state
- cfg_stride  in  STRIDE_W  window step; 0 treated as 1; sampled on accepted start
- cfg_first_level, cfg_last_level  in  LEVEL_W  inclusive level range; sampled on start
- level_req  out  1  request loader to present level level_idx
- level_idx  out  LEVEL_W  level being requested/scanned
- level_ack  in  1  loader has presented level_idx
- win_valid  out  1  window coordinate valid
- win_ready  in  1  pipeline accepts window (next_scan_win)
- win_row, win_col  out  COORD_W  window top-left
- win_last_level  out  1  current window is last of its level
- win_last  out  1  current window is last of job
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at job completion
- cfg_err  out  1  one-cycle pulse on rejected start
- win_count  out  32  windows accepted this job

## Operation
- States: IDLE, LEVEL, WAIT, SCAN, DONE.
- IDLE: on start, validate the range. If first > last or last >= LEVELS: pulse cfg_err and stay in IDLE. Otherwise latch the config, set level_idx = first, clear win_count, go to LEVEL.
- LEVEL: level_req = 1. On level_ack: if INT_WAIT = 0 go to SCAN, else load the wait counter and go to WAIT.
- WAIT: count INT_WAIT cycles, then go to SCAN with row = col = 0.
- SCAN: win_valid = 1; coordinates hold until valid & ready. Then win_count increments.
- Limits: maxc = width[level] - WIN, maxr = height[level] - WIN.
- Step: if col < maxc, col = min(col + stride, maxc). Else col = 0 and row = min(row + stride, maxr). Clamping guarantees the right and bottom edges are covered.
- Level end: handshake at (maxr, maxc). If level_idx == last go to DONE; else level_idx + 1, row = col = 0, go to LEVEL.
- DONE: done = 1 for one cycle, then IDLE.
- abort wins over every other event: next state IDLE, all outputs deasserted. win_count holds its value.
- start while busy is ignored.
- Level with maxr = maxc = 0: exactly one window, with win_last_level = 1.
- Coordinate arithmetic is done at COORD_W + 1 bits before clamping; no wrap is permitted.

## Timing
- Reset values: level_req, win_valid, win_last_level, win_last, busy, done, cfg_err = 0. level_idx, win_row, win_col = 0. win_count = 0. State IDLE.
- start in cycle t → level_req = 1 in t+1.
- level_ack in cycle a → win_valid = 1 in cycle a+1+INT_WAIT.
- With win_ready held at 1, one window is issued per cycle, including across row wrap.
- Each level boundary costs at least 1 + INT_WAIT idle cycles plus the loader's ack latency.
- Last handshake in cycle t → done = 1 in t+1, busy = 0 in t+2.
- level_ack outside LEVEL is ignored. win_ready while win_valid = 0 is ignored.

## Structure
- Shared package vj_scan_pkg holds the state enum typedef (scan_state_t) and the default constants WIN and INT_WAIT. The pyramid dimension macros stay in vj_weights.vh.
- One natural sub-module: clamp_stepper, a single-axis counter with stride, limit and wrap flag. It is instantiated twice, once for columns and once for rows; the row instance is enabled by the column wrap.

## Test plan
Common configuration: LEVELS=3, WIN=4, INT_WAIT=3, widths {8,6,4}, heights {6,5,4} for levels 0..2.

- Stride 1, levels 0..2, win_ready = 1, immediate ack → 15 + 6 + 1 = 22 windows, win_count = 22, done exactly once, win_last only on level 2 (0,0).
- Stride 3, level 0 only → windows (0,0)(0,3)(0,4)(2,0)(2,3)(2,4); win_last_level on (2,4).
- win_ready random 50%, level_ack delayed 5 cycles → same 22-coordinate sequence as the first test; coordinates stable while valid & !ready; first win_valid 4 cycles after each ack.
- cfg_first_level = 2, cfg_last_level = 1 → cfg_err pulse, busy stays 0. Then a valid start → job runs normally.
- abort asserted during WAIT of level 1, and again mid-SCAN → IDLE next cycle, win_valid = 0, level_req = 0, no done pulse.
- reset asserted mid-SCAN → all outputs at reset values immediately (asynchronous); a following start runs the full job from level first.
